// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one shared partial-product adder, one digit per cycle.
// Latency: out_valid rises NUM_DIGITS cycles after the accept edge; issue interval NUM_DIGITS+2.
// Backpressure: product is held in DONE while out_ready=0; operands are accepted only in IDLE.
module booth_mul_seq #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     multiplicand,
    input  logic [DATA_WIDTH-1:0]     multiplier,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic                      busy
);

    localparam int NUM_DIGITS = (DATA_WIDTH + 1) / 2;
    localparam int PW         = 2 * DATA_WIDTH;
    localparam int BW         = 2 * NUM_DIGITS;
    localparam int CW         = $clog2(NUM_DIGITS) + 1;
    localparam int SW         = CW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [BW:0]            b_q;
    logic [PW-1:0]          acc_q;
    logic [PW-1:0]          product_q;
    logic [CW-1:0]          cnt_q;

    logic [BW-1:0]          b_sx;
    logic [SW-1:0]          sh;
    logic [2:0]             trip;
    logic [PW-1:0]          a_ext;
    logic [PW-1:0]          sel;
    logic                   neg;
    logic [PW-1:0]          pp;
    logic [PW-1:0]          acc_nxt;
    logic                   last_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CALC;
            CALC:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Odd widths get one extra multiplier bit carrying B's sign.
    always_comb begin
        b_sx                 = {BW{multiplier[DATA_WIDTH-1]}};
        b_sx[DATA_WIDTH-1:0] = multiplier;
    end

    // Booth triplet {b[2i+1], b[2i], b[2i-1]}; b_q[0] is the implicit b[-1]=0.
    always_comb begin
        sh         = {cnt_q, 1'b0};
        trip       = b_q[sh +: 3];
        a_ext      = {{(PW-DATA_WIDTH){a_q[DATA_WIDTH-1]}}, a_q};
        last_digit = (cnt_q == CW'(NUM_DIGITS - 1));
        sel        = '0;
        neg        = 1'b0;
        case (trip)
            3'b001, 3'b010: sel = a_ext;
            3'b011:         sel = a_ext << 1;
            3'b100: begin
                sel = a_ext << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = a_ext;
                neg = 1'b1;
            end
            default:        sel = '0;
        endcase
        // Negation as inverted operand plus carry-in.
        pp      = (neg ? ~sel : sel) + {{(PW-1){1'b0}}, neg};
        acc_nxt = acc_q + (pp << sh);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q   <= multiplicand;
                b_q   <= {b_sx, 1'b0};
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state == CALC) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + 1'b1;
                if (last_digit) begin
                    product_q <= acc_nxt;
                end
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomized bench for booth_mul_seq against a plain signed-multiply reference.
module tb_booth_mul_seq;

    localparam int DW = 6;
    localparam int PW = 2 * DW;
    localparam int ND = (DW + 1) / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] multiplicand = '0;
    logic [DW-1:0] multiplier = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] product;
    logic          busy;

    int checks = 0;
    int errors = 0;

    booth_mul_seq #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic signed [DW-1:0] a,
                                              input logic signed [DW-1:0] b);
        logic signed [PW-1:0] x;
        logic signed [PW-1:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    // One full transaction: accept, scramble inputs during CALC, stall, then drain.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [PW-1:0] exp, input int stall, input bit hold);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk("in_ready_calc", 32'(in_ready), 32'd0);
            chk("busy_calc", 32'(busy), 32'd1);
            multiplicand = DW'($urandom);
            multiplier   = DW'($urandom);
            out_ready    = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        chk("latency", 32'(lat), 32'(ND));
        chk("product", 32'(product), 32'(exp));
        repeat (stall) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_product", 32'(product), 32'(exp));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_product_hold", 32'(product), 32'(exp));
    endtask

    initial begin
        logic [DW-1:0] ra, rb;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;

        do_op(6'b110101, 6'b011011, 12'hED7, 0, 1'b0);
        do_op(6'b100000, 6'b100000, 12'h400, 0, 1'b0);
        do_op(6'd31,     6'd31,     12'h3C1, 0, 1'b0);
        do_op(6'b100000, 6'd31,     12'hC20, 0, 1'b0);
        do_op(6'd0,      6'b111111, 12'h000, 0, 1'b0);
        do_op(6'd5,      6'b111101, 12'hFF1, 10, 1'b0);
        do_op(6'd7,      6'd9,      12'h03F, 2, 1'b1);

        // Reset during the second CALC cycle discards the operation.
        @(negedge clk);
        multiplicand = 6'd13;
        multiplier   = 6'd11;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        do_op(6'b111111, 6'b111111, 12'h001, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            do_op(ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 3)), 1'($urandom));
            @(negedge clk);
            chk("idle_no_valid", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
